bram_stream_reader: RTL
=======================

// Module: bram_stream_reader
// PURPOSE
//  Read-side sequencer for a dual-port BRAM read-first port (either latency setting). Accepts a burst command,
//  issues sequential reads on one BRAM port, returns the data as a valid/ready stream with a LAST marker.
//  Absorbs the 1- or 2-cycle BRAM read latency with credit-limited issue and a small output FIFO,
//  so backpressure never loses data. Sits between the BRAM and any streaming consumer (DMA, WCI/WSI egress).
// PARAMETERS
//  PIPELINED   0   must equal the attached BRAM's PIPELINED; read latency L = 1 + PIPELINED
//  ADDR_WIDTH  10  BRAM address width
//  DATA_WIDTH  32  BRAM data width
//  MEMSIZE     1024 BRAM depth in words; address wraps MEMSIZE-1 -> 0
//  LEN_WIDTH   12  burst length field width
// PORTS
//  CLK         in   1           clock; BRAM port clock must be this same clock
//  RST         in   1           synchronous reset, active-high
//  CMD_VALID   in   1           burst command valid
//  CMD_READY   out  1           command accepted when CMD_VALID & CMD_READY
//  CMD_ADDR    in   ADDR_WIDTH  first word address (< MEMSIZE)
//  CMD_LEN     in   LEN_WIDTH   word count minus one (0 -> 1 word)
//  BRAM_EN     out  1           BRAM port enable
//  BRAM_WE     out  1           tied 0
//  BRAM_ADDR   out  ADDR_WIDTH  BRAM port address
//  BRAM_DO     in   DATA_WIDTH  BRAM port read data
//  OUT_VALID   out  1           stream data valid
//  OUT_READY   in   1           consumer ready
//  OUT_DATA    out  DATA_WIDTH  stream data
//  OUT_LAST    out  1           final word of burst
//  BUSY        out  1           high from command accept until last word transferred
// BEHAVIOUR
//  Reset: CMD_READY=0 during RST, 1 the cycle after; BRAM_EN=0, BRAM_ADDR=0, OUT_VALID=0, OUT_LAST=0, BUSY=0.
//  FSM IDLE -> ISSUE -> DRAIN -> IDLE.
//   IDLE: CMD_READY=1; on handshake latch addr, remaining=CMD_LEN, BUSY=1, go ISSUE (first EN next cycle).
//   ISSUE: BRAM_EN=1 iff inflight + fifo_count < FIFO_DEPTH; each issue addr wraps, remaining--;
//          issue with remaining==0 tags LAST, go DRAIN.
//   DRAIN: no issue; OUT handshake with OUT_LAST=1 -> IDLE, BUSY=0 same edge. CMD_READY=0 outside IDLE.
//  FIFO_DEPTH = L + 1. Tag shift register (length L, valid+last) advances every cycle;
//   BRAM_DO captured into FIFO exactly L cycles after its BRAM_EN, independent of OUT_READY.
//  Credit check counts the tag pipeline and FIFO, so FIFO can never overflow; overflow is an assertion error.
//  Stream: OUT_DATA/OUT_LAST stable while OUT_VALID & !OUT_READY. Sustained 1 word/cycle when OUT_READY held 1.
//  Empty FIFO: OUT_VALID=0; write into empty FIFO shows OUT_VALID next cycle (no comb bypass).
//  Simultaneous FIFO push and pop: both occur, count unchanged.
//  Address: next = (addr == MEMSIZE-1) ? 0 : addr+1.
//  RST mid-burst: FSM->IDLE, tag pipeline and FIFO cleared; BRAM data still returning is discarded.
//  Inputs CMD_ADDR >= MEMSIZE: undefined; assertion flags it.
// STRUCTURE
//  Shared package bram_stream_pkg: FSM state encodings (IDLE/ISSUE/DRAIN), read-latency function of PIPELINED,
//   FIFO_DEPTH derivation.
//  One sub-module: bram_stream_fifo (DEPTH x (DATA_WIDTH+1) sync FIFO, count output, registered outputs).
//  Top holds FSM, address/remaining counters, tag shift register, credit compare.
// TESTING
//  Use a behavioural model of the BRAM (read-first, PIPELINED 0 and 1) preloaded with RAM[i]=i.
//  T1: PIPELINED=0, cmd addr=5 len=3, OUT_READY=1 -> data 5,6,7,8, LAST on 8, 4 consecutive beats.
//  T2: PIPELINED=1, cmd addr=0 len=7, OUT_READY toggling 1,0 -> 0..7 in order; FIFO count never > 3.
//  T3: MEMSIZE=16, cmd addr=14 len=3 -> BRAM_ADDR 14,15,0,1; data 14,15,0,1.
//  T4: OUT_READY=0 for 20 cycles mid-burst -> BRAM_EN stops after credits exhausted, no word lost/duplicated.
//  T5: len=0 single word -> one beat with OUT_LAST=1; CMD_READY back to 1 the cycle after that handshake.
//  T6: RST asserted 2 cycles into a len=9 burst -> no OUT_VALID after reset; next cmd addr=3 len=1 yields 3,4 only.

Source files
------------

// File: rtl/bram_stream_pkg.sv
// Shared definitions for the BRAM stream reader.
//  - state_t      : sequencer states (idle, issuing reads, draining)
//  - read_latency : BRAM read latency in cycles for a PIPELINED setting
//  - fifo_depth   : output FIFO depth that covers one full latency window
package bram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  function automatic int read_latency(input int pipelined);
    return (pipelined != 0) ? 2 : 1;
  endfunction

  // One slot per read in flight plus one so a stalled head word does not
  // starve the issue side.
  function automatic int fifo_depth(input int pipelined);
    return read_latency(pipelined) + 1;
  endfunction

endpackage

// File: rtl/bram_stream_fifo.sv
// Small synchronous FIFO holding {last, data} words returned by the BRAM.
// Ports:
//  CLK, RST   clock and synchronous active-high reset
//  push       write push_data this cycle (caller guarantees space)
//  push_data  word to store
//  pop        consume the head word (ignored when empty)
//  valid      head word present
//  data       head word, held stable until popped
//  count      number of stored words
// Outputs come from registers only, so a word written into an empty FIFO
// becomes visible the following cycle.
module bram_stream_fifo #(
  parameter int DEPTH     = 2,
  parameter int WIDTH     = 33,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic                 valid,
  output logic [WIDTH-1:0]     data,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && valid;
  assign valid  = (count != '0);
  assign data   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Push and pop in the same cycle both take effect and leave count unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // The reader's credit check should make overflow impossible.
  always_ff @(posedge CLK) begin
    if (!RST && push && !do_pop) begin
      assert (count != FULL_COUNT);
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side sequencer for one read-first BRAM port.
// Accepts a burst command, issues sequential reads, and returns the words as
// a valid/ready stream with a LAST marker. Reads are only issued when the
// output FIFO is guaranteed to have room when the data comes back, so
// consumer backpressure never drops a word.
// Ports:
//  CLK, RST             clock and synchronous active-high reset
//  CMD_VALID/CMD_READY  burst command handshake
//  CMD_ADDR, CMD_LEN    first word address, word count minus one
//  BRAM_EN/WE/ADDR/DO   BRAM port (WE always 0)
//  OUT_VALID/OUT_READY  output stream handshake
//  OUT_DATA, OUT_LAST   stream word and end-of-burst marker
//  BUSY                 burst in progress
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MEMSIZE    = 1024,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [LEN_WIDTH-1:0]  CMD_LEN,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [DATA_WIDTH-1:0] BRAM_DO,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_LAST,
  output logic                  BUSY
);

  localparam int LAT        = read_latency(PIPELINED);
  localparam int FIFO_DEPTH = fifo_depth(PIPELINED);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W      = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMSIZE - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LAT-1:0]        tag_valid;
  logic [LAT-1:0]        tag_last;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_last;
  logic                  cmd_fire;
  logic                  out_fire;
  logic                  issue;
  logic                  issue_last;
  logic                  credit_ok;
  logic [SUM_W-1:0]      inflight;
  logic [SUM_W-1:0]      committed;

  assign cmd_fire   = CMD_VALID && CMD_READY;
  assign out_fire   = OUT_VALID && OUT_READY;
  assign issue_last = issue && (remaining == '0);
  assign BRAM_EN    = issue;
  assign BRAM_WE    = 1'b0;
  assign BRAM_ADDR  = addr;
  assign BUSY       = (state != ST_IDLE);
  assign OUT_LAST   = OUT_VALID && fifo_last;

  // Every read in the tag pipeline will land in the FIFO, so it already owns
  // a slot. A word leaving this cycle frees its slot immediately, which is
  // what keeps a full-rate stream going at one word per cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + SUM_W'(tag_valid[i]);
    end
    committed = inflight + SUM_W'(fifo_count) - SUM_W'(out_fire);
    credit_ok = (committed < SUM_W'(FIFO_DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    CMD_READY  = 1'b0;
    issue      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        CMD_READY = !RST;
        if (CMD_VALID && !RST) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue = credit_ok && !RST;
        if (issue && (remaining == '0)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_fire && OUT_LAST) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr      <= '0;
      remaining <= '0;
    end else if (cmd_fire) begin
      addr      <= CMD_ADDR;
      remaining <= CMD_LEN;
    end else if (issue) begin
      addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  // The tag for each read reaches the last stage in the same cycle its data
  // appears on BRAM_DO, so that stage drives the FIFO write directly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_valid <= '0;
      tag_last  <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      tag_valid[0] <= issue;
      tag_last[0]  <= issue_last;
    end
  end

  bram_stream_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .WIDTH     (DATA_WIDTH + 1),
    .CNT_WIDTH (CNT_W)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (tag_valid[LAT-1]),
    .push_data ({tag_last[LAT-1], BRAM_DO}),
    .pop       (out_fire),
    .valid     (OUT_VALID),
    .data      ({fifo_last, OUT_DATA}),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (!RST && cmd_fire) begin
      assert (CMD_ADDR <= LAST_ADDR);
    end
  end

endmodule
